// File: rtl/conv_pkg.sv
// conv_pkg: shared widths and the round/shift/saturate helper for the 3x3 conv MAC.
package conv_pkg;
    localparam int DATA_W = 8;
    localparam int PROD_W = 16;
    localparam int SUM_W  = 20;
    localparam int ACC_W  = 21;
    localparam int BIAS_W = 16;
    localparam int NTAPS  = 9;
    localparam logic signed [ACC_W:0] SAT_HI = 127;
    localparam logic signed [ACC_W:0] SAT_LO = -128;

    // One extra bit so the half-up rounding constant can never overflow the accumulator
    function automatic logic signed [DATA_W-1:0] sat8(input logic signed [ACC_W-1:0] acc, input logic [3:0] sh);
        logic [ACC_W:0] half;
        logic signed [ACC_W:0] r;
        half = (ACC_W + 1)'(1) << sh;
        half = half >> 1;
        r = {acc[ACC_W-1], acc} + $signed(half);
        r = r >>> sh;
        return r > SAT_HI ? 8'sd127 : r < SAT_LO ? -8'sd128 : r[DATA_W-1:0];
    endfunction
endpackage

// File: rtl/conv3x3_adder_tree.sv
// conv3x3_adder_tree: sums nine signed products into a registered 20-bit sum.
module conv3x3_adder_tree
    import conv_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic signed [PROD_W-1:0] prod [NTAPS],
    output logic signed [SUM_W-1:0]  sum,
    output logic                     out_valid
);
    logic signed [SUM_W-1:0] s;

    always_comb begin
        s = '0;
        for (int i = 0; i < NTAPS; i++) s = s + SUM_W'(prod[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) sum <= s;
        end
    end
endmodule

// File: rtl/conv3x3_window_mac.sv
// conv3x3_window_mac: 3x3 window MAC with bias, requantisation and frame tracking.
// Optional CONV_RELU_EN clamps negative outputs to zero.
module conv3x3_window_mac #(
    parameter int SHIFT  = 4,
    parameter int DATA_W = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               w_load,
    input  logic signed [DATA_W-1:0]           w_data,
    input  logic signed [conv_pkg::BIAS_W-1:0] bias,
    input  logic [7:0]                         img_width,
    input  logic [7:0]                         img_height,
    input  logic                               win_valid,
    input  logic signed [DATA_W-1:0]           win0,
    input  logic signed [DATA_W-1:0]           win1,
    input  logic signed [DATA_W-1:0]           win2,
    input  logic signed [DATA_W-1:0]           win3,
    input  logic signed [DATA_W-1:0]           win4,
    input  logic signed [DATA_W-1:0]           win5,
    input  logic signed [DATA_W-1:0]           win6,
    input  logic signed [DATA_W-1:0]           win7,
    input  logic signed [DATA_W-1:0]           win8,
    output logic                               weights_rdy,
    output logic                               pix_valid,
    output logic signed [DATA_W-1:0]           pix_out,
    output logic                               frame_done
);
    import conv_pkg::*;

    logic signed [DATA_W-1:0] w [NTAPS];
    logic signed [DATA_W-1:0] win [NTAPS];
    logic signed [PROD_W-1:0] prod [NTAPS];
    logic signed [SUM_W-1:0]  sum;
    logic signed [BIAS_W-1:0] bias_r;
    logic signed [ACC_W-1:0]  acc;
    logic signed [DATA_W-1:0] sat, q;
    logic [3:0] w_idx;
    logic [7:0] col, row;
    logic fire, v1, v2, last;

    assign win  = '{win0, win1, win2, win3, win4, win5, win6, win7, win8};
    // Windows arriving while the taps are incomplete or being rewritten are discarded
    assign fire = win_valid && weights_rdy && !w_load;
    assign acc  = ACC_W'(sum) + ACC_W'(bias_r);
    assign sat  = sat8(acc, 4'(SHIFT));
`ifdef CONV_RELU_EN
    assign q = sat[DATA_W-1] ? '0 : sat;
`else
    assign q = sat;
`endif
    assign last = col == img_width - 8'd1 && row == img_height - 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NTAPS; i++) w[i] <= '0;
            w_idx       <= '0;
            weights_rdy <= 1'b0;
        end else if (w_load) begin
            w[w_idx]    <= w_data;
            w_idx       <= w_idx == 4'd8 ? 4'd0 : w_idx + 4'd1;
            weights_rdy <= w_idx == 4'd8 ? 1'b1 : w_idx == 4'd0 ? 1'b0 : weights_rdy;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NTAPS; i++) prod[i] <= '0;
            v1     <= 1'b0;
            bias_r <= '0;
        end else begin
            v1     <= fire;
            bias_r <= bias;
            if (fire) for (int i = 0; i < NTAPS; i++) prod[i] <= w[i] * win[i];
        end
    end

    conv3x3_adder_tree u_tree (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v1),
        .prod      (prod),
        .sum       (sum),
        .out_valid (v2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_valid  <= 1'b0;
            pix_out    <= '0;
            frame_done <= 1'b0;
            col        <= '0;
            row        <= '0;
        end else begin
            pix_valid  <= v2;
            frame_done <= v2 && last;
            if (v2) begin
                pix_out <= q;
                col     <= col == img_width - 8'd1 ? 8'd0 : col + 8'd1;
                if (col == img_width - 8'd1) row <= row == img_height - 8'd1 ? 8'd0 : row + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_conv3x3_window_mac.sv
// tb_conv3x3_window_mac: directed scoreboard bench for conv3x3_window_mac (default SHIFT=4).
module tb_conv3x3_window_mac;
    localparam int SH = 4;
    localparam int W = 4;
    localparam int H = 4;

    typedef struct {int pix; bit done; int due;} exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic w_load, win_valid;
    logic signed [7:0] w_data;
    logic signed [15:0] bias;
    logic [7:0] img_width, img_height;
    logic signed [7:0] wv [9];
    logic weights_rdy, pix_valid, frame_done;
    logic signed [7:0] pix_out;

    int cyc = 0;
    int total = 0;
    int passed = 0;
    int fails = 0;
    int done_seen = 0;
    int mw [9];
    int nw [9];
    int win_t [9];
    int bias_i;
    bit m_rdy;
    int mcol, mrow;
    exp_t q [$];

    conv3x3_window_mac #(.SHIFT(SH), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .w_load(w_load), .w_data(w_data), .bias(bias),
        .img_width(img_width), .img_height(img_height), .win_valid(win_valid),
        .win0(wv[0]), .win1(wv[1]), .win2(wv[2]), .win3(wv[3]), .win4(wv[4]),
        .win5(wv[5]), .win6(wv[6]), .win7(wv[7]), .win8(wv[8]),
        .weights_rdy(weights_rdy), .pix_valid(pix_valid), .pix_out(pix_out), .frame_done(frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    function automatic int model();
        int acc = bias_i;
        for (int k = 0; k < 9; k++) acc += mw[k] * win_t[k];
        acc = (acc + (1 << (SH - 1))) >>> SH;
        acc = acc > 127 ? 127 : acc < -128 ? -128 : acc;
`ifdef CONV_RELU_EN
        if (acc < 0) acc = 0;
`endif
        return acc;
    endfunction

    task automatic drive_taps();
        for (int k = 0; k < 9; k++) wv[k] = 8'(win_t[k]);
    endtask

    task automatic send_win();
        exp_t e;
        @(posedge clk); #1;
        w_load = 1'b0;
        win_valid = 1'b1;
        drive_taps();
        if (m_rdy) begin
            e.pix = model();
            e.done = mcol == W - 1 && mrow == H - 1;
            e.due = cyc + 3;
            q.push_back(e);
            mcol = mcol == W - 1 ? 0 : mcol + 1;
            if (e.done) mrow = 0;
            else if (mcol == 0) mrow++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            w_load = 1'b0;
            win_valid = 1'b0;
        end
    endtask

    task automatic load_w(input int pause_at, input bit with_win);
        for (int k = 0; k < 9; k++) begin
            if (k == pause_at) send_win();
            @(posedge clk); #1;
            if (k == 1) check("rdy_drop_on_reload", weights_rdy, 0);
            w_load = 1'b1;
            w_data = 8'(nw[k]);
            win_valid = with_win;
            drive_taps();
            mw[k] = nw[k];
            if (k == 0) m_rdy = 1'b0;
        end
        @(posedge clk); #1;
        w_load = 1'b0;
        win_valid = 1'b0;
        m_rdy = 1'b1;
        check("weights_rdy_set", weights_rdy, 1);
    endtask

    task automatic set_win(input int c, input int o);
        for (int k = 0; k < 9; k++) win_t[k] = k == 4 ? c : o;
    endtask

    task automatic set_w(input int c, input int o);
        for (int k = 0; k < 9; k++) nw[k] = k == 4 ? c : o;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (q.size() > 0 && q[0].due == cyc) begin
                exp_t e;
                e = q.pop_front();
                check("pix_valid_on_time", pix_valid, 1);
                if (pix_valid) begin
                    check("pix_out", pix_out, e.pix);
                    check("frame_done", frame_done, int'(e.done));
                end
            end else begin
                check("no_spurious_valid", pix_valid, 0);
                check("no_spurious_done", frame_done, 0);
            end
            if (pix_valid && frame_done) done_seen++;
        end
    end

    initial begin
        int d0;
        rst_n = 1'b0;
        w_load = 1'b0;
        win_valid = 1'b0;
        w_data = '0;
        bias = '0;
        bias_i = 0;
        img_width = 8'(W);
        img_height = 8'(H);
        m_rdy = 1'b0;
        mcol = 0;
        mrow = 0;
        for (int k = 0; k < 9; k++) begin mw[k] = 0; win_t[k] = 0; end
        drive_taps();
        repeat (3) @(posedge clk);
        #1;
        check("rst_pix_valid", pix_valid, 0);
        check("rst_pix_out", pix_out, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_weights_rdy", weights_rdy, 0);
        rst_n = 1'b1;
        set_win(37, 5);
        send_win();
        set_w(16, 0);
        load_w(8, 1'b1);
        idle(4);
        send_win();
        set_win(-50, 99);
        send_win();
        idle(4);
        set_w(16, 16);
        set_win(100, 100);
        send_win();
        set_w(-16, -16);
        load_w(0, 1'b0);
        send_win();
        idle(4);
        set_w(1, 0);
        load_w(9, 1'b0);
        foreach (win_t[k]) win_t[k] = 0;
        win_t[4] = 24;  send_win();
        win_t[4] = -24; send_win();
        win_t[4] = 8;   send_win();
        win_t[4] = -8;  send_win();
        win_t[4] = -9;  send_win();
        idle(4);
        bias = 16'sd1000;
        bias_i = 1000;
        idle(2);
        win_t[4] = 0;
        send_win();
        idle(4);
        send_win();
        send_win();
        @(posedge clk); #1;
        win_valid = 1'b0;
        rst_n = 1'b0;
        q.delete();
        m_rdy = 1'b0;
        mcol = 0;
        mrow = 0;
        foreach (mw[k]) mw[k] = 0;
        #1;
        check("midrst_pix_valid", pix_valid, 0);
        check("midrst_frame_done", frame_done, 0);
        check("midrst_weights_rdy", weights_rdy, 0);
        idle(3);
        rst_n = 1'b1;
        idle(4);
        bias = -16'sd300;
        bias_i = -300;
        foreach (nw[k]) nw[k] = int'($urandom_range(0, 40)) - 20;
        load_w(9, 1'b0);
        d0 = done_seen;
        for (int n = 0; n < 2 * W * H; n++) begin
            foreach (win_t[k]) win_t[k] = int'($urandom_range(0, 255)) - 128;
            send_win();
        end
        idle(6);
        check("frame_pulses", done_seen - d0, 2);
        check("scoreboard_empty", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
